mem_port_arbiter: RTL

- Shares the single unified memory of the multicycle MIPS core between two requesters: instruction fetch (IorD=0 path) and data load/store (IorD=1 path).
- Grants one transaction at a time using round-robin when both request.
- Sequences the memory handshake: issue, fixed-latency wait, response.
- Returns read data to the granted requester.
- Sits between the main control FSM/datapath and the memory block.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the unified memory between instruction fetch and data load/store
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t            r_state;
  logic              r_ptr_d;
  logic              r_gnt_d;
  logic              r_we;
  logic [3:0]        r_cnt;
  logic              r_mem_re, r_mem_we, r_if_ack, r_d_ack, r_if_rvalid, r_d_rvalid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic              w_gnt_d;
  logic              w_cap;
  // data side wins when it is the only requester or when the pointer names it
  assign w_gnt_d = d_req && (!if_req || r_ptr_d);
  // mem_rdata is sampled on the edge that enters RESP, so rdata and rvalid appear together
  assign w_cap   = (r_state == S_WAIT && r_cnt == 4'd1) ||
                   (r_state == S_ISSUE && !r_we && MEM_LAT == 1);
  // single FSM: grant, issue, fixed-latency wait, response; every output is registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr_d     <= 1'b0;
      r_gnt_d     <= 1'b0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_cap) begin
        r_state     <= S_RESP;
        r_if_rvalid <= !r_gnt_d;
        r_d_rvalid  <= r_gnt_d;
        if (r_gnt_d) r_d_rdata <= mem_rdata;
        else         r_if_rdata <= mem_rdata;
      end else begin
        case (r_state)
          S_IDLE: if (if_req || d_req) begin
            r_state    <= S_ISSUE;
            r_gnt_d    <= w_gnt_d;
            r_ptr_d    <= !w_gnt_d;
            r_we       <= w_gnt_d && d_we;
            r_mem_addr <= w_gnt_d ? d_addr : if_addr;
            if (w_gnt_d) r_mem_wdata <= d_wdata;
            r_mem_re   <= !(w_gnt_d && d_we);
            r_mem_we   <= w_gnt_d && d_we;
            r_if_ack   <= !w_gnt_d;
            r_d_ack    <= w_gnt_d;
          end
          S_ISSUE: begin
            r_state <= r_we ? S_IDLE : S_WAIT;
            r_cnt   <= 4'(MEM_LAT - 1);
          end
          S_WAIT:  r_cnt <= r_cnt - 4'd1;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign if_ack    = r_if_ack;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_ack     = r_d_ack;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);
endmodule
